pm_loader: RTL and testbench
============================

Name: pm_loader

Overview:
- Write-side counterpart of the fetch path: receives a byte stream (from the boot/debug link) and writes assembled 32-bit instruction words into Program Memory at consecutive 16-bit addresses.
- Holds the CPU fetch pipeline off (cpu_hold) while loading.
- Verifies a trailing XOR checksum byte.
- Sits between the serial front end and the Program Memory write port; the PC/fetch block reads what this block writes.

Parameters:
- ADDR_W, 16, program-memory address width (matches PC width).
- DATA_W, 32, instruction word width; fixed at 4 bytes per word.
- BASE_ADDR, 16'h0000, first write address of every load.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request a load; sampled only in IDLE.
- load_len  input  16  number of words to load; latched on accepted start.
- byte_in  input  8  incoming data byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- pm_we  output  1  program-memory write enable, one-cycle pulse per word.
- pm_addr  output  ADDR_W  program-memory write address.
- pm_din  output  DATA_W  program-memory write data.
- cpu_hold  output  1  high while a load is in progress; drives fetch stall/reset.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at end of load.
- error  output  1  checksum mismatch; sticky until next accepted start.

Behaviour:
- Reset (async): state IDLE. All outputs 0: byte_ready, pm_we, pm_addr, pm_din, cpu_hold, busy, done, error. Word shift register, byte count, word count and running XOR also clear.
- Byte handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_valid may drop at any time with no effect. byte_ready is registered and is a function of state only.
- States: IDLE, COLLECT, WRITE, CHECK, DONE.
- IDLE: byte_ready=0, cpu_hold=0.
  - start=1, load_len!=0: latch load_len, set addr=BASE_ADDR, clear byte count/XOR/error, go to COLLECT. cpu_hold=1 from the next cycle.
  - start=1, load_len==0: go to DONE. error=0, no writes, no checksum byte consumed.
- COLLECT: byte_ready=1. Each accepted byte does:
  - word <= {word[23:0], byte_in} (first byte lands in [31:24], big-endian).
  - xor <= xor ^ byte_in.
  - byte count++.
  - The 4th accepted byte moves to WRITE.
- WRITE (exactly 1 cycle): byte_ready=0, pm_we=1, pm_addr=addr, pm_din=word. Then:
  - addr <= addr+1, modulo 2^ADDR_W (FFFF wraps to 0000).
  - words_left--.
  - If words_left was 1, go to CHECK; else return to COLLECT with byte count 0.
  - Latency: pm_we is asserted the cycle after the 4th byte is accepted. Peak throughput is 4 bytes per 5 cycles.
- CHECK: byte_ready=1. On the accepted byte, error <= (byte_in != xor); go to DONE.
- DONE (1 cycle): done=1, cpu_hold=1, byte_ready=0. Then go to IDLE, where cpu_hold=0.
- pm_addr and pm_din hold their last values when pm_we=0.
- start outside IDLE is ignored; it does not restart or queue.
- Reset mid-load: immediate return to IDLE with all outputs 0 and no further pm_we. Words already written stay in memory. The next start begins again at BASE_ADDR.
- busy=1 in every state except IDLE.

Test Plan:
- Normal load: BASE_ADDR=0, load_len=2, bytes 12 34 56 78 9A BC DE F0, checksum 00 -> pm_we with (0000, 12345678), then (0001, 9ABCDEF0). One-cycle done pulse, error=0. cpu_hold high from the cycle after start through DONE, 0 in IDLE.
- Bad checksum: same stream with checksum 01 -> identical writes, done pulse, error=1 held until the next start, which clears it.
- Throttled source: byte_valid toggled 1/0 with random gaps of 0-3 cycles -> same two writes and data, no byte lost or duplicated. byte_ready=0 during each WRITE cycle.
- Wrap and restart: BASE_ADDR=FFFF, load_len=2 -> writes at FFFF then 0000. A start pulse held during the load is ignored: still exactly 2 writes and 1 done.
- Zero length: load_len=0, start -> done=1 exactly one cycle later. No pm_we, byte_ready never 1, error=0.
- Reset mid-load: assert reset asynchronously after 2 bytes of word 0 -> all outputs 0 immediately, no pm_we. A new load of 1 word (AA BB CC DD, checksum 00) writes AABBCCDD at BASE_ADDR.

Source files
------------

// File: rtl/pm_loader.sv
`default_nettype none
// ============================================================================
// Module  : pm_loader
// Brief   : Assembles a big-endian byte stream into 32-bit words, writes them
//           to Program Memory, holds the CPU and checks a trailing XOR byte.
// Rev     : 1.0
// ============================================================================
module pm_loader #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_words_left;
    logic [1:0]          r_byte_cnt;
    logic [7:0]          r_xor;
    logic [DATA_W-1:0]   r_word;

    logic                w_accept;
    logic [DATA_W-1:0]   w_next_word;

    assign w_accept    = byte_valid && byte_ready;
    assign w_next_word = {r_word[DATA_W-9:0], byte_in};

    // Outputs are registered and set for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_words_left <= '0;
            r_byte_cnt   <= '0;
            r_xor        <= '0;
            r_word       <= '0;
            byte_ready   <= 1'b0;
            pm_we        <= 1'b0;
            pm_addr      <= '0;
            pm_din       <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            pm_we <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        if (load_len != 16'd0) begin
                            r_words_left <= load_len;
                            r_addr       <= BASE_ADDR;
                            r_byte_cnt   <= 2'd0;
                            r_xor        <= 8'd0;
                            byte_ready   <= 1'b1;
                            r_state      <= S_COLLECT;
                        end else begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_word     <= w_next_word;
                        r_xor      <= r_xor ^ byte_in;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            byte_ready <= 1'b0;
                            pm_we      <= 1'b1;
                            pm_addr    <= r_addr;
                            pm_din     <= w_next_word;
                            r_state    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr       <= r_addr + 1'b1;
                    r_words_left <= r_words_left - 16'd1;
                    r_byte_cnt   <= 2'd0;
                    byte_ready   <= 1'b1;
                    r_state      <= (r_words_left == 16'd1) ? S_CHECK : S_COLLECT;
                end
                S_CHECK: begin
                    if (w_accept) begin
                        error      <= (byte_in != r_xor);
                        byte_ready <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pm_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_pm_loader
// Brief   : Randomised bench for pm_loader; two instances (base 0000 / FFFF)
//           checked every cycle against a byte-stream level reference model.
// Rev     : 1.0
// ============================================================================
module tb_pm_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        rdy  [2];
    logic        we   [2];
    logic [15:0] addr [2];
    logic [31:0] din  [2];
    logic        hold [2];
    logic        bsy  [2];
    logic        dn   [2];
    logic        err  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pm_loader #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(16'h0000)) dut0 (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy[0]),
        .pm_we(we[0]), .pm_addr(addr[0]), .pm_din(din[0]), .cpu_hold(hold[0]),
        .busy(bsy[0]), .done(dn[0]), .error(err[0]));

    pm_loader #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(16'hFFFF)) dut1 (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy[1]),
        .pm_we(we[1]), .pm_addr(addr[1]), .pm_din(din[1]), .cpu_hold(hold[1]),
        .busy(bsy[1]), .done(dn[1]), .error(err[1]));

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    // Reference model: tracks how many stream bytes have arrived out of the
    // total the load needs (4 per word plus one checksum byte).
    logic        e_ready [2], e_we [2], e_hold [2], e_busy [2], e_done [2], e_err [2];
    logic [15:0] e_addr  [2];
    logic [31:0] e_din   [2];
    int          m_total [2], m_rx [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_word  [2];
    logic [7:0]  m_xor   [2];
    logic [47:0] wlog0 [$], wlog1 [$];
    int          done_cnt [2];

    always @(negedge clk) begin
        bit   acc;
        logic cur_we, cur_done;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                chk("rst_ready", d, rdy[d], 0);  chk("rst_we", d, we[d], 0);
                chk("rst_addr", d, addr[d], 0);  chk("rst_din", d, din[d], 0);
                chk("rst_hold", d, hold[d], 0);  chk("rst_busy", d, bsy[d], 0);
                chk("rst_done", d, dn[d], 0);    chk("rst_error", d, err[d], 0);
                e_ready[d] = 0; e_we[d] = 0; e_hold[d] = 0; e_busy[d] = 0;
                e_done[d] = 0;  e_err[d] = 0; e_addr[d] = 0; e_din[d] = 0;
                m_total[d] = 0; m_rx[d] = 0;  m_addr[d] = 0; m_word[d] = 0; m_xor[d] = 0;
            end else begin
                chk("byte_ready", d, rdy[d], e_ready[d]); chk("pm_we", d, we[d], e_we[d]);
                chk("pm_addr", d, addr[d], e_addr[d]);    chk("pm_din", d, din[d], e_din[d]);
                chk("cpu_hold", d, hold[d], e_hold[d]);   chk("busy", d, bsy[d], e_busy[d]);
                chk("done", d, dn[d], e_done[d]);         chk("error", d, err[d], e_err[d]);
                if (we[d]) begin
                    if (d == 0) wlog0.push_back({addr[d], din[d]});
                    else        wlog1.push_back({addr[d], din[d]});
                end
                if (dn[d]) done_cnt[d]++;

                acc      = byte_valid && e_ready[d];
                cur_we   = e_we[d];
                cur_done = e_done[d];
                e_we[d]   = 0;
                e_done[d] = 0;
                if (cur_done) begin
                    e_hold[d] = 0;
                    e_busy[d] = 0;
                end else if (m_total[d] == 0) begin
                    if (start) begin
                        e_err[d]  = 0;
                        e_busy[d] = 1;
                        e_hold[d] = 1;
                        if (load_len == 16'd0) begin
                            e_done[d] = 1;
                        end else begin
                            m_total[d] = int'(load_len) * 4 + 1;
                            m_rx[d]    = 0;
                            m_addr[d]  = (d == 0) ? 16'h0000 : 16'hFFFF;
                            m_xor[d]   = 8'h00;
                            e_ready[d] = 1;
                        end
                    end
                end else if (cur_we) begin
                    m_addr[d]  = m_addr[d] + 16'd1;
                    e_ready[d] = 1;
                end else if (acc) begin
                    m_rx[d]++;
                    if (m_rx[d] == m_total[d]) begin
                        e_err[d]   = (byte_in != m_xor[d]);
                        e_done[d]  = 1;
                        e_ready[d] = 0;
                        m_total[d] = 0;
                    end else begin
                        m_xor[d]  = m_xor[d] ^ byte_in;
                        m_word[d] = {m_word[d][23:0], byte_in};
                        if (m_rx[d] % 4 == 0) begin
                            e_we[d]    = 1;
                            e_addr[d]  = m_addr[d];
                            e_din[d]   = m_word[d];
                            e_ready[d] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [15:0] len, input bit keep);
        start    = 1'b1;
        load_len = len;
        tick();
        if (!keep) start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input int gap);
        int n = 0;
        bit got = 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            tick();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        while (!got && n < 40) begin
            @(negedge clk);
            got = rdy[0];
            tick();
            n++;
        end
        byte_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL feed_timeout: byte %h never accepted after %0d cycles", b, n);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn[0] && n < 30);
        if (!dn[0]) begin
            checks++; errors++;
            $display("FAIL done_timeout: done not seen after %0d cycles", n);
        end
        tick();
        repeat (2) tick();
    endtask

    task automatic load(input logic [15:0] len, input logic [7:0] bs [$], input int gap, input bit keep);
        do_start(len, keep);
        foreach (bs[i]) feed(bs[i], (gap > 0) ? int'($urandom_range(0, gap)) : 0);
        start = 1'b0;
        wait_done();
    endtask

    task automatic clear_logs();
        wlog0.delete();
        wlog1.delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    endtask

    initial begin
        logic [7:0] good [$];
        logic [7:0] bad  [$];
        logic [7:0] bs   [$];
        logic [7:0] x;
        int len;

        good = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        bad  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
        reset = 1'b1; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Normal load
        clear_logs();
        load(16'd2, good, 0, 0);
        chk("normal_wr_count", 0, wlog0.size(), 2);
        chk("normal_w0", 0, wlog0[0], {16'h0000, 32'h12345678});
        chk("normal_w1", 0, wlog0[1], {16'h0001, 32'h9ABCDEF0});
        chk("wrap_w0", 1, wlog1[0], {16'hFFFF, 32'h12345678});
        chk("wrap_w1", 1, wlog1[1], {16'h0000, 32'h9ABCDEF0});
        chk("normal_error", 0, err[0], 0);
        chk("normal_done_cnt", 0, done_cnt[0], 1);

        // Bad checksum; error stays until the next start
        clear_logs();
        load(16'd2, bad, 0, 0);
        chk("bad_w1", 0, wlog0[1], {16'h0001, 32'h9ABCDEF0});
        repeat (5) tick();
        chk("bad_error_sticky", 0, err[0], 1);

        // Throttled source
        clear_logs();
        load(16'd2, good, 3, 0);
        chk("thr_wr_count", 0, wlog0.size(), 2);
        chk("thr_w0", 0, wlog0[0], {16'h0000, 32'h12345678});
        chk("thr_w1", 0, wlog0[1], {16'h0001, 32'h9ABCDEF0});
        chk("thr_error", 0, err[0], 0);

        // Start held throughout the load is ignored
        clear_logs();
        load(16'd2, good, 1, 1);
        repeat (5) tick();
        chk("hold_wr_count", 1, wlog1.size(), 2);
        chk("hold_wrap_w1", 1, wlog1[1], {16'h0000, 32'h9ABCDEF0});
        chk("hold_done_cnt", 1, done_cnt[1], 1);

        // Zero length
        clear_logs();
        bs.delete();
        load(16'd0, bs, 0, 0);
        chk("zero_wr_count", 0, wlog0.size(), 0);
        chk("zero_done_cnt", 0, done_cnt[0], 1);
        chk("zero_error", 0, err[0], 0);

        // Reset after two bytes of word 0
        clear_logs();
        do_start(16'd1, 0);
        feed(8'hAA, 0);
        feed(8'hBB, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", 0, bsy[0], 0);
        chk("async_rst_hold", 0, hold[0], 0);
        chk("async_rst_ready", 0, rdy[0], 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_no_write", 0, wlog0.size(), 0);
        bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        load(16'd1, bs, 0, 0);
        chk("after_rst_wr_count", 0, wlog0.size(), 1);
        chk("after_rst_w0", 0, wlog0[0], {16'h0000, 32'hAABBCCDD});
        chk("after_rst_w0_base", 1, wlog1[0], {16'hFFFF, 32'hAABBCCDD});

        // Random loads, checked by the model only
        for (int t = 0; t < 8; t++) begin
            len = int'($urandom_range(1, 4));
            bs.delete();
            x = 8'h00;
            for (int i = 0; i < len * 4; i++) begin
                bs.push_back(8'($urandom));
                x = x ^ bs[i];
            end
            if ($urandom_range(0, 1) == 1) x = x ^ 8'($urandom_range(1, 255));
            bs.push_back(x);
            clear_logs();
            load(16'(len), bs, 3, ($urandom_range(0, 3) == 0));
            chk("rand_wr_count", 0, wlog0.size(), len);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
